// File: rtl/mdu_ctrl_pkg.sv
// Shared opcode bit positions, sequencer states and small helpers for the
// multiply/divide unit.
package mdu_ctrl_pkg;

    localparam int unsigned MDOP_W     = 8;
    localparam int unsigned MDOP_MULT  = 0;
    localparam int unsigned MDOP_MULTU = 1;
    localparam int unsigned MDOP_DIV   = 2;
    localparam int unsigned MDOP_DIVU  = 3;
    localparam int unsigned MDOP_MTHI  = 4;
    localparam int unsigned MDOP_MTLO  = 5;
    localparam int unsigned MDOP_MFHI  = 6;
    localparam int unsigned MDOP_MFLO  = 7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_DFIX = 3'd3,
        S_DZ   = 3'd4
    } mdu_state_e;

    function automatic logic is_onehot(input logic [MDOP_W-1:0] op);
        return (op != '0) && ((op & (op - MDOP_W'(1))) == '0);
    endfunction

    // Magnitude of a signed operand; unsigned operands pass through untouched.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? 32'(-x) : x;
    endfunction

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// Unsigned restoring radix-2 divider core: one quotient bit per enabled step,
// 32 steps after start for a full result.
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        step_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic [32:0] shifted_c;
    logic        fits_c;

    // quo_q shifts the dividend out at the top while quotient bits enter below.
    assign shifted_c = {rem_q, quo_q[31]};
    assign fits_c    = shifted_c >= {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (start_i) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            quo_q <= {quo_q[30:0], fits_c};
            rem_q <= fits_c ? 32'(shifted_c - {1'b0, dvs_q}) : shifted_c[31:0];
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, runs MUL_LAT-cycle multiplies and
// 33-cycle divides, and stalls execute while an op is in flight.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid_i,
    input  logic [MDOP_W-1:0] mduop_i,
    input  logic [31:0]       opr1_i,
    input  logic [31:0]       opr2_i,
    input  logic              ex_stall_i,
    input  logic              ex_flush_i,
    output logic [31:0]       hilo_rdata_o,
    output logic              mdu_is_active_o,
    output logic              mdu_div_active_o,
    output logic              mdu_stall_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o
);

    localparam int unsigned      CNT_W        = 5;
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(31);
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q, lo_q;
    logic [31:0]      mul_a_q, mul_b_q;
    logic             mul_signed_q, neg_quo_q, neg_rem_q;

    logic             fire_c, op_mul_c, op_div_c, div_signed_c;
    logic             div_start_c, div_step_c;
    logic [31:0]      div_a_c, div_b_c, quo_c, rem_c;
    logic [63:0]      mul_a64_c, mul_b64_c, product_c;

    assign fire_c       = issue_valid_i & ~ex_stall_i & ~ex_flush_i
                        & (state_q == S_IDLE) & is_onehot(mduop_i);
    assign op_mul_c     = mduop_i[MDOP_MULT] | mduop_i[MDOP_MULTU];
    assign op_div_c     = mduop_i[MDOP_DIV] | mduop_i[MDOP_DIVU];
    assign div_signed_c = mduop_i[MDOP_DIV];
    assign div_start_c  = fire_c & op_div_c & (opr2_i != '0);
    assign div_step_c   = (state_q == S_DIV);
    assign div_a_c      = mag32(opr1_i, div_signed_c);
    assign div_b_c      = mag32(opr2_i, div_signed_c);

    // Low 64 bits of the extended product are exact for both signednesses.
    assign mul_a64_c = mul_signed_q ? {{32{mul_a_q[31]}}, mul_a_q} : {32'd0, mul_a_q};
    assign mul_b64_c = mul_signed_q ? {{32{mul_b_q[31]}}, mul_b_q} : {32'd0, mul_b_q};
    assign product_c = mul_a64_c * mul_b64_c;

    div_iter u_div_iter (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start_c),
        .step_i     (div_step_c),
        .dividend_i (div_a_c),
        .divisor_i  (div_b_c),
        .quotient_o (quo_c),
        .remainder_o(rem_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_signed_q <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fire_c) begin
                        if (mduop_i[MDOP_MTHI]) hi_q <= opr1_i;
                        if (mduop_i[MDOP_MTLO]) lo_q <= opr1_i;
                        if (op_mul_c) begin
                            mul_a_q      <= opr1_i;
                            mul_b_q      <= opr2_i;
                            mul_signed_q <= mduop_i[MDOP_MULT];
                            cnt_q        <= MUL_CNT_INIT;
                            state_q      <= S_MUL;
                        end
                        if (op_div_c) begin
                            if (opr2_i == '0) begin
                                state_q <= S_DZ;
                            end else begin
                                neg_quo_q <= div_signed_c & (opr1_i[31] ^ opr2_i[31]);
                                neg_rem_q <= div_signed_c & opr1_i[31];
                                cnt_q     <= DIV_CNT_INIT;
                                state_q   <= S_DIV;
                            end
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == '0) begin
                        {hi_q, lo_q} <= product_c;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (cnt_q == '0) state_q <= S_DFIX;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                S_DFIX: begin
                    lo_q    <= neg_quo_q ? 32'(-quo_c) : quo_c;
                    hi_q    <= neg_rem_q ? 32'(-rem_c) : rem_c;
                    state_q <= S_IDLE;
                end
                S_DZ:    state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mdu_is_active_o  = (state_q != S_IDLE);
    assign mdu_div_active_o = (state_q == S_DIV) | (state_q == S_DFIX);
    assign mdu_stall_o      = issue_valid_i & mdu_is_active_o;
    assign hilo_rdata_o     = mduop_i[MDOP_MFHI] ? hi_q : lo_q;
    assign hi_o             = hi_q;
    assign lo_o             = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus random ops compared
// against an arithmetic HI/LO and latency model.
module tb_mdu_ctrl;

    localparam int unsigned MUL_LAT = 2;
    localparam logic [7:0] OP_MULT  = 8'h01;
    localparam logic [7:0] OP_MULTU = 8'h02;
    localparam logic [7:0] OP_DIV   = 8'h04;
    localparam logic [7:0] OP_DIVU  = 8'h08;
    localparam logic [7:0] OP_MTHI  = 8'h10;
    localparam logic [7:0] OP_MTLO  = 8'h20;
    localparam logic [7:0] OP_MFHI  = 8'h40;
    localparam logic [7:0] OP_MFLO  = 8'h80;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [7:0]  mduop;
    logic [31:0] opr1, opr2;
    logic        ex_stall, ex_flush;
    logic [31:0] hilo_rdata, hi, lo;
    logic        is_active, div_active, stall;

    always #5 clk = ~clk;

    mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid_i   (issue_valid),
        .mduop_i         (mduop),
        .opr1_i          (opr1),
        .opr2_i          (opr2),
        .ex_stall_i      (ex_stall),
        .ex_flush_i      (ex_flush),
        .hilo_rdata_o    (hilo_rdata),
        .mdu_is_active_o (is_active),
        .mdu_div_active_o(div_active),
        .mdu_stall_o     (stall),
        .hi_o            (hi),
        .lo_o            (lo)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Architectural effect of one op on HI/LO, plus busy and divide-busy cycle counts.
    task automatic model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic killed, output int lat, output int dlat);
        longint      sa, sb;
        logic [63:0] p;
        lat  = 0;
        dlat = 0;
        if (killed || $countones(op) != 1) return;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT:  begin p = 64'(sa * sb); {m_hi, m_lo} = p; lat = int'(MUL_LAT); end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; lat = int'(MUL_LAT); end
            OP_DIV: begin
                if (b == 0) lat = 1;
                else begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                    lat  = 33;
                    dlat = 33;
                end
            end
            OP_DIVU: begin
                if (b == 0) lat = 1;
                else begin
                    m_lo = a / b;
                    m_hi = a % b;
                    lat  = 33;
                    dlat = 33;
                end
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op from idle, then measure how long the unit stays busy.
    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic flush, input logic xstall);
        int          lat, dlat, busy, dbusy;
        logic [31:0] exp_rd;
        exp_rd = (op == OP_MFHI) ? m_hi : m_lo;
        model(op, a, b, flush | xstall, lat, dlat);
        issue_valid = 1'b1;
        mduop       = op;
        opr1        = a;
        opr2        = b;
        ex_flush    = flush;
        ex_stall    = xstall;
        #1;
        chk({tag, ".stall_idle"}, 32'(stall), 32'd0);
        if ($countones(op) == 1) chk({tag, ".rdata"}, hilo_rdata, exp_rd);
        @(posedge clk); #1;
        issue_valid = 1'b0;
        mduop       = '0;
        ex_flush    = 1'b0;
        ex_stall    = 1'b0;
        busy  = 0;
        dbusy = 0;
        while (is_active && busy < 100) begin
            busy++;
            if (div_active) dbusy++;
            @(posedge clk); #1;
        end
        chk({tag, ".busy"}, 32'(busy), 32'(lat));
        chk({tag, ".divbusy"}, 32'(dbusy), 32'(dlat));
        chk({tag, ".hi"}, hi, m_hi);
        chk({tag, ".lo"}, lo, m_lo);
    endtask

    initial begin
        int          n, lat, dlat, k;
        logic [7:0]  op;
        logic [31:0] a, b;

        rst = 1'b1; issue_valid = 1'b0; mduop = '0; opr1 = '0; opr2 = '0;
        ex_stall = 1'b0; ex_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        issue_valid = 1'b1;
        mduop       = OP_MFLO;
        #1;
        chk("reset.active", 32'(is_active), 32'd0);
        chk("reset.divactive", 32'(div_active), 32'd0);
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.hi", hi, 32'd0);
        chk("reset.lo", lo, 32'd0);
        issue_valid = 1'b0;
        mduop       = '0;
        rst         = 1'b0;
        @(posedge clk); #1;

        run_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        chk("mult.hi_const", hi, 32'hFFFF_FFFF);
        chk("mult.lo_const", lo, 32'hFFFF_FFFE);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        chk("multu.hi_const", hi, 32'h0000_0001);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div_neg.lo_const", lo, 32'hFFFF_FFFD);
        chk("div_neg.hi_const", hi, 32'hFFFF_FFFF);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
        chk("divu.lo_const", lo, 32'd14);
        chk("divu.hi_const", hi, 32'd2);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("div_ovf.lo_const", lo, 32'h8000_0000);
        run_op("div_negdvs", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("mthi", OP_MTHI, 32'h1234, 32'd0, 1'b0, 1'b0);
        run_op("mtlo", OP_MTLO, 32'h5678, 32'd0, 1'b0, 1'b0);
        run_op("divu0", OP_DIVU, 32'd55, 32'd0, 1'b0, 1'b0);
        chk("divu0.hi_const", hi, 32'h1234);
        run_op("div0", OP_DIV, 32'hFFFF_0000, 32'd0, 1'b0, 1'b0);
        run_op("mult_flush", OP_MULT, 32'd3, 32'd5, 1'b1, 1'b0);
        run_op("mult_exstall", OP_MULTU, 32'd3, 32'd5, 1'b0, 1'b1);
        run_op("mthi_dead", OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        run_op("mfhi", OP_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
        run_op("op_zero", 8'h00, 32'd9, 32'd3, 1'b0, 1'b0);
        run_op("op_multi", 8'h05, 32'd9, 32'd3, 1'b0, 1'b0);

        // MFLO presented right behind a divide stalls until the result lands.
        model(OP_DIV, 32'd20, 32'd3, 1'b0, lat, dlat);
        issue_valid = 1'b1; mduop = OP_DIV; opr1 = 32'd20; opr2 = 32'd3;
        @(posedge clk); #1;
        mduop = OP_MFLO;
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("mflo_stall.cycles", 32'(n), 32'(lat));
        chk("mflo_stall.rdata", hilo_rdata, 32'd6);
        mduop = OP_MFHI;
        #1;
        chk("mfhi_after.rdata", hilo_rdata, 32'd2);
        @(posedge clk); #1;
        issue_valid = 1'b0; mduop = '0;

        for (int i = 0; i < 60; i++) begin
            k  = int'($urandom_range(0, 9));
            op = (k < 8) ? 8'(1 << k) : ((k == 8) ? 8'h00 : 8'h0C);
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), op, a, b,
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        // Reset in cycle 10 of a divide aborts it without touching HI/LO beyond the clear.
        issue_valid = 1'b1; mduop = OP_DIV; opr1 = 32'd1000; opr2 = 32'd7;
        @(posedge clk); #1;
        mduop = OP_MFLO;
        repeat (9) @(posedge clk);
        #1;
        chk("rst_mid.divactive_before", 32'(div_active), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("rst_mid.active", 32'(is_active), 32'd0);
        chk("rst_mid.stall", 32'(stall), 32'd0);
        chk("rst_mid.hi", hi, 32'd0);
        chk("rst_mid.lo", lo, 32'd0);
        issue_valid = 1'b0; mduop = '0;
        run_op("post_rst_multu", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencer and owner of the HI/LO registers for the multiply/divide unit behind the execute stage.
- Accepts one MDU op per cycle from execute and runs a MUL_LAT-cycle multiply or a 33-cycle iterative divide.
- Produces the busy/div-busy indications and the stall request consumed by execute, and serves MFHI/MFLO reads combinationally.

Parameters:
MUL_LAT, 2, cycles from multiply issue to HI/LO update (legal range 1..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
issue_valid_i  in  1  an MDU instruction is present in execute
mduop_i  in  8  one-hot MDU opcode (MDOP)
opr1_i  in  32  rs value / MT* data
opr2_i  in  32  rt value
ex_stall_i  in  1  execute stage frozen this cycle (no issue)
ex_flush_i  in  1  execute-stage instruction killed this cycle
hilo_rdata_o  out  32  HI when MFHI, else LO (combinational)
mdu_is_active_o  out  1  state != IDLE
mdu_div_active_o  out  1  state is DIV or DFIX
mdu_stall_o  out  1  issue_valid_i & mdu_is_active_o
hi_o  out  32  architectural HI
lo_o  out  32  architectural LO

Behaviour:
- Interface: one clock, clk; reset rst, synchronous, active-high. All state is updated on the rising edge of clk.
- Reset values: state=IDLE, HI=0, LO=0, counters=0. Consequently mdu_is_active_o=0, mdu_div_active_o=0, mdu_stall_o=0.
- Reset asserted mid-operation aborts the op. No HI/LO write occurs.
- Issue condition: fire = issue_valid_i & ~ex_stall_i & ~ex_flush_i & state==IDLE.
- Flush affects only the issuing instruction. An op already in flight always completes, because it is older than the flushed instruction.
- MTHI/MTLO on fire: HI (resp. LO) <= opr1_i at that edge. State stays IDLE.
- MFHI/MFLO: no state change. hilo_rdata_o is valid in the issue cycle. A read while busy raises mdu_stall_o until IDLE.
- MULT/MULTU on fire:
  - Latch operands; state <- MUL, cnt <- MUL_LAT-1.
  - In MUL: decrement cnt. When cnt==0, {HI,LO} <= 64-bit product (signed or unsigned) and state <- IDLE.
  - Result: busy in cycles t+1..t+MUL_LAT; HI/LO updated at edge ending cycle t+MUL_LAT.
- DIV/DIVU on fire:
  - Divisor==0: state <- DZ for one cycle, then IDLE. HI/LO unchanged.
  - Otherwise: latch magnitudes (DIVU uses raw values) and the signs; state <- DIV, cnt <- 31.
  - DIV performs one restoring radix-2 step per cycle. At cnt==0, state <- DFIX.
  - DFIX: apply signs (quotient negated if s1^s2, remainder takes the dividend sign; unsigned ops skip this). Then LO <= quotient, HI <= remainder, state <- IDLE.
  - Busy 33 cycles (t+1..t+33); HI/LO written at end of t+33.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wrap, no exception).
- Back-to-back ops: an op presented in the completion cycle stalls. It fires the next cycle and sees the updated HI/LO.
- Opcode rules:
  - A non-one-hot or zero mduop_i with issue_valid_i is ignored: no fire, no stall unless busy.
  - Exactly one op per cycle.
- mdu_stall_o depends on issue_valid_i and state only, never on ex_stall_i (no combinational loop).

Decomposition:
- Shared defines file:
  - MDOP_W=8 and the bit indices MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MFHI=6, MFLO=7.
  - State encodings IDLE, MUL, DIV, DFIX, DZ.
- One sub-module, div_iter: a 32-step unsigned restoring divider core (start, step enable, quotient, remainder).
- The multiply uses the inferred product, registered through the MUL_LAT pipeline in mdu_ctrl.

Test Plan:
- MULT opr1=0xFFFFFFFF, opr2=2 at cycle t -> busy t+1..t+2; cycle t+3: HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV opr1=0xFFFFFFF9 (-7), opr2=2 -> mdu_div_active_o high exactly 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU by 0 with HI=0x1234, LO=0x5678 -> busy exactly 1 cycle, HI/LO unchanged.
- MFLO presented the cycle after DIV 20/3 issues -> mdu_stall_o high 33 cycles; first non-stall cycle hilo_rdata_o=6. MFHI then returns 2.
- MULT presented with ex_flush_i=1 -> no state change, busy stays 0. MTHI 0xDEADBEEF then MFHI next cycle -> 0xDEADBEEF.
- rst pulsed at cycle 10 of a DIV -> next cycle IDLE, HI=LO=0, stall deasserted.
